// File: rtl/rtc_pkg.sv
// Shared constants for the RTC read-address sequencer: register address table,
// timer-scan start index and FSM state encoding.
package rtc_pkg;

    localparam int RTC_N_TABLE     = 11;
    localparam int RTC_TIMER_FIRST = 8;

    // Time/date registers first, then the three timer registers.
    localparam logic [7:0] RTC_RD_TABLE [RTC_N_TABLE] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
        8'h27, 8'h28, 8'h41, 8'h42, 8'h43
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } rtc_state_e;

    function automatic logic [7:0] rtc_table_addr(input logic [3:0] idx);
        logic [7:0] addr;
        addr = 8'h00;
        if (int'(idx) < RTC_N_TABLE) begin
            addr = RTC_RD_TABLE[idx];
        end
        return addr;
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Control inputs and read-request bus between the mode FSM, the sequencer and
// the RTC bus controller.
interface rtc_read_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              escribe;
    logic              inicio;
    logic              crono;
    logic              oneshot;
    logic              rd_ack;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              rd_req;
    logic [3:0]        index;
    logic              frame_done;
    logic              err_timeout;

    modport master (
        input  escribe, inicio, crono, oneshot, rd_ack,
        output address, addr_valid, rd_req, index, frame_done, err_timeout
    );

    modport slave (
        output escribe, inicio, crono, oneshot, rd_ack,
        input  address, addr_valid, rd_req, index, frame_done, err_timeout
    );
endinterface

// File: rtl/rtc_dwell_timer.sv
// Cycle counter shared by the ack timeout and the post-ack dwell. Counts from 1
// after a clear; hit_o flags the cycle in which the count equals DWELL.
module rtc_dwell_timer #(
    parameter int                 DWELL_W = 12,
    parameter logic [DWELL_W-1:0] DWELL   = DWELL_W'(12'h04A)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = DWELL_W'(1);
        end else if (en_i) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == DWELL);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Walks the RTC register table, issuing each address with a rd_req/rd_ack
// handshake followed by a fixed dwell; full or timer-only scans, optional one-shot.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int                 ADDR_W      = 8,
    parameter int                 N_ENTRIES   = RTC_N_TABLE,
    parameter int                 TIMER_FIRST = RTC_TIMER_FIRST,
    parameter int                 DWELL_W     = 12,
    parameter logic [DWELL_W-1:0] DWELL       = DWELL_W'(12'h04A)
) (
    input logic                  clk,
    input logic                  reset,
    rtc_read_sequencer_if.master bus
);

    localparam logic [3:0] LAST_IDX  = 4'(N_ENTRIES - 1);
    localparam logic [3:0] FIRST_TMR = 4'(TIMER_FIRST);

    rtc_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              fdone_q, fdone_d;
    logic              tout_q, tout_d;
    logic              run;
    logic              dwell_hit;
    logic              tmr_clr;
    logic              tmr_en;

    assign run = bus.crono | (~bus.escribe & ~bus.inicio);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fdone_d = 1'b0;
        tout_d  = 1'b0;
        if (!run) begin
            // Dropping run abandons any pending request silently.
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ISSUE;
                    idx_d   = bus.crono ? FIRST_TMR : 4'd0;
                end
                ST_ISSUE: begin
                    // An ack on the timeout cycle still counts as accepted.
                    if (bus.rd_ack) begin
                        state_d = ST_HOLD;
                    end else if (dwell_hit) begin
                        state_d = ST_NEXT;
                        tout_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dwell_hit) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx_q < LAST_IDX) begin
                        state_d = ST_ISSUE;
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        fdone_d = 1'b1;
                        if (bus.oneshot) begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_ISSUE;
                            idx_d   = bus.crono ? FIRST_TMR : 4'd0;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        valid_d = (state_d == ST_ISSUE) || (state_d == ST_HOLD);
        req_d   = (state_d == ST_ISSUE);
        addr_d  = valid_d ? ADDR_W'(rtc_table_addr(idx_d)) : '0;
        tmr_clr = (state_d != state_q);
        tmr_en  = (state_q == ST_ISSUE) || (state_q == ST_HOLD);
    end

    rtc_dwell_timer #(
        .DWELL_W (DWELL_W),
        .DWELL   (DWELL)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .hit_o (dwell_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fdone_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fdone_q <= fdone_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.address     = addr_q;
    assign bus.addr_valid  = valid_q;
    assign bus.rd_req      = req_q;
    assign bus.index       = idx_q;
    assign bus.frame_done  = fdone_q;
    assign bus.err_timeout = tout_q;

endmodule
